// File: rtl/serial_sum_collector.sv
// serial_sum_collector: receive end of a bit-serial adder.
// Takes two LSB-first operand streams, adds them with a registered carry,
// deserialises the sum into a WIDTH-bit word and offers it on a valid/ready port.
// Optional build macro: SERIAL_SUB_EN adds a 'sub' input (sampled with start)
// that turns the datapath into an A-B subtractor with a no-borrow flag on cout.
module serial_sum_collector #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  input  logic             bit_valid,
  input  logic             a_bit,
  input  logic             b_bit,
  output logic             busy,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_carry;
  logic [CNT_W-1:0]   r_count;
  logic [WIDTH-1:0]   r_shreg;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_valid;
  logic               r_busy;

  state_t             w_state_nxt;
  logic               w_carry_nxt;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [WIDTH-1:0]   w_shreg_nxt;
  logic [WIDTH-1:0]   w_sum_nxt;
  logic               w_cout_nxt;
  logic               w_valid_nxt;
  logic               w_busy_nxt;

  logic               w_b_eff;
  logic               w_init_carry;
  logic               w_s;
  logic               w_c;
  logic               w_last;
  logic [WIDTH-1:0]   w_shifted;

`ifdef SERIAL_SUB_EN
  logic               r_sub;
  logic               w_sub_nxt;

  // Subtract mode inverts B and seeds the carry with 1 (two's complement).
  assign w_b_eff      = b_bit ^ r_sub;
  assign w_init_carry = sub;
`else
  assign w_b_eff      = b_bit;
  assign w_init_carry = 1'b0;
`endif

  // One full-adder slice per accepted bit pair.
  assign w_s       = a_bit ^ w_b_eff ^ r_carry;
  assign w_c       = (a_bit & w_b_eff) | (a_bit & r_carry) | (w_b_eff & r_carry);
  assign w_last    = (r_count == CNT_W'(WIDTH - 1));
  // New bit enters at the MSB; after WIDTH shifts the first bit sits at the LSB.
  assign w_shifted = WIDTH'({w_s, r_shreg} >> 1);

  // Next-state and datapath update; everything holds unless a branch changes it.
  always_comb begin
    w_state_nxt = r_state;
    w_carry_nxt = r_carry;
    w_count_nxt = r_count;
    w_shreg_nxt = r_shreg;
    w_sum_nxt   = r_sum;
    w_cout_nxt  = r_cout;
    w_valid_nxt = r_valid;
`ifdef SERIAL_SUB_EN
    w_sub_nxt   = r_sub;
`endif

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_ACCUM;
          w_carry_nxt = w_init_carry;
          w_count_nxt = '0;
          w_shreg_nxt = '0;
`ifdef SERIAL_SUB_EN
          w_sub_nxt   = sub;
`endif
        end
      end
      S_ACCUM: begin
        if (start) begin
          // Abort and restart; the bit pair presented this cycle is dropped.
          w_carry_nxt = w_init_carry;
          w_count_nxt = '0;
          w_shreg_nxt = '0;
`ifdef SERIAL_SUB_EN
          w_sub_nxt   = sub;
`endif
        end else if (bit_valid) begin
          w_carry_nxt = w_c;
          w_shreg_nxt = w_shifted;
          w_count_nxt = r_count + CNT_W'(1);
          if (w_last) begin
            w_sum_nxt   = w_shifted;
            w_cout_nxt  = w_c;
            w_valid_nxt = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt == S_ACCUM);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_carry <= 1'b0;
      r_count <= '0;
      r_shreg <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
`ifdef SERIAL_SUB_EN
      r_sub   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_carry <= w_carry_nxt;
      r_count <= w_count_nxt;
      r_shreg <= w_shreg_nxt;
      r_sum   <= w_sum_nxt;
      r_cout  <= w_cout_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
`ifdef SERIAL_SUB_EN
      r_sub   <= w_sub_nxt;
`endif
    end
  end

  assign busy      = r_busy;
  assign sum_out   = r_sum;
  assign cout      = r_cout;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_serial_sum_collector.sv
// Directed bench for serial_sum_collector (WIDTH=4); sub tests only when
// SERIAL_SUB_EN is defined.
module tb_serial_sum_collector;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       bit_valid;
  logic       a_bit;
  logic       b_bit;
  logic       busy;
  logic [3:0] sum_out;
  logic       cout;
  logic       out_valid;
  logic       out_ready;
`ifdef SERIAL_SUB_EN
  logic       sub;
`endif

  int n_cmp;
  int n_fail;

  serial_sum_collector #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
`ifdef SERIAL_SUB_EN
    .sub       (sub),
`endif
    .bit_valid (bit_valid),
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .busy      (busy),
    .sum_out   (sum_out),
    .cout      (cout),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Send one LSB-first word with 'gap' idle cycles between bits.
  task automatic send_word(input logic [3:0] a, input logic [3:0] b, input int gap);
    for (int i = 0; i < 4; i++) begin
      a_bit = a[i];
      b_bit = b[i];
      bit_valid = 1'b1;
      step();
      bit_valid = 1'b0;
      if (i < 3) begin
        check("no_early_valid", 32'(out_valid), 32'd0);
        check("busy_accum", 32'(busy), 32'd1);
        for (int g = 0; g < gap; g++) begin
          step();
          check("busy_gap", 32'(busy), 32'd1);
        end
      end
    end
  endtask

  task automatic begin_word();
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [3:0] s, input logic c);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sum"}, 32'(sum_out), 32'(s));
    check({tag, "_cout"}, 32'(cout), 32'(c));
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("hs_valid_low", 32'(out_valid), 32'd0);
    check("hs_busy_low", 32'(busy), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    start = 1'b0;
    bit_valid = 1'b0;
    a_bit = 1'b0;
    b_bit = 1'b0;
    out_ready = 1'b0;
`ifdef SERIAL_SUB_EN
    sub = 1'b0;
`endif
    step();
    step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum_out), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    step();

    // 5 + 3 back-to-back
    begin_word();
    send_word(4'd5, 4'd3, 0);
    check_result("add53", 4'b1000, 1'b0);
    step();
    step();
    check("add53_hold_valid", 32'(out_valid), 32'd1);
    handshake();
    check("add53_sum_kept", 32'(sum_out), 32'd8);

    // 15 + 1 with 2-cycle gaps
    begin_word();
    send_word(4'd15, 4'd1, 2);
    check_result("add151", 4'b0000, 1'b1);

    // Backpressure: toggle bit_valid/start while held
    for (int i = 0; i < 5; i++) begin
      bit_valid = i[0];
      start = ~i[0];
      a_bit = 1'b1;
      b_bit = 1'b1;
      step();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_sum", 32'(sum_out), 32'd0);
      check("bp_cout", 32'(cout), 32'd1);
    end
    bit_valid = 1'b0;
    start = 1'b0;
    handshake();

    // Bits in IDLE are ignored
    bit_valid = 1'b1;
    a_bit = 1'b1;
    b_bit = 1'b1;
    step();
    step();
    bit_valid = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_valid", 32'(out_valid), 32'd0);

    // Abort after 2 bits, restart with start+bit_valid (bit dropped), then 2+2
    begin_word();
    for (int i = 0; i < 2; i++) begin
      a_bit = 1'b1;
      b_bit = 1'b1;
      bit_valid = 1'b1;
      step();
    end
    start = 1'b1;
    step();
    start = 1'b0;
    bit_valid = 1'b0;
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_valid", 32'(out_valid), 32'd0);
    send_word(4'd2, 4'd2, 0);
    check_result("add22", 4'd4, 1'b0);
    handshake();

    // Reset after 3 bits discards the word
    begin_word();
    for (int i = 0; i < 3; i++) begin
      a_bit = 1'b1;
      b_bit = 1'b0;
      bit_valid = 1'b1;
      step();
    end
    bit_valid = 1'b0;
    rst_n = 1'b0;
    step();
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sum", 32'(sum_out), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    a_bit = 1'b1;
    bit_valid = 1'b1;
    step();
    step();
    bit_valid = 1'b0;
    check("postrst_valid", 32'(out_valid), 32'd0);
    check("postrst_busy", 32'(busy), 32'd0);

`ifdef SERIAL_SUB_EN
    // 5 - 3
    sub = 1'b1;
    begin_word();
    sub = 1'b0;
    send_word(4'd5, 4'd3, 0);
    check_result("sub53", 4'b0010, 1'b1);
    handshake();
    // 3 - 5
    sub = 1'b1;
    begin_word();
    sub = 1'b0;
    send_word(4'd3, 4'd5, 1);
    check_result("sub35", 4'b1110, 1'b0);
    handshake();
`endif

    // Plain add with sub low (or absent)
    begin_word();
    send_word(4'd5, 4'd3, 0);
    check_result("add53b", 4'd8, 1'b0);
    handshake();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
